pool2x2_engine: RTL and testbench
=================================

// Module: pool2x2_engine
// PURPOSE
//  Layer-1 stage downstream of the 3x3 convolution/ReLU stage. Reads the 64x64 layer-0 map (20-bit, post-ReLU)
//  from shared result memory, computes 2x2 stride-2 max-pooling and writes the 32x32 layer-1 map back.
//  Shares the ready/busy handshake and crd/cwr/csel memory protocol of the result-memory bus.
// PARAMETERS
//  DW       20      data width of layer-0/layer-1 pixels
//  AW       12      read/write address width
//  IMG_W    64      layer-0 side length (power of 2); output side = IMG_W/2
//  SEL_IN   3'b001  csel value selecting layer-0 memory (read source)
//  SEL_OUT  3'b011  csel value selecting layer-1 memory (write target)
// PORTS
//  clk       in   1   clock; all state changes on rising edge
//  reset     in   1   asynchronous, active-low reset
//  ready     in   1   start request; sampled only in IDLE
//  busy      out  1   high from cycle after ready accepted until after last write
//  crd       out  1   memory read strobe
//  caddr_rd  out  AW  read address (row*IMG_W+col)
//  cdata_rd  in   DW  read data; memory drives it at the falling edge of a crd cycle
//  cwr       out  1   memory write strobe, sampled by memory at rising edge
//  caddr_wr  out  AW  write address (orow*IMG_W/2+ocol)
//  cdata_wr  out  DW  write data
//  csel      out  3   memory select: SEL_IN during reads, SEL_OUT during writes, 3'b000 in IDLE
// BEHAVIOUR
//  - Reset (reset==0, async): state IDLE; busy,crd,cwr=0; caddr_rd,caddr_wr,cdata_wr=0; csel=3'b000;
//    window counters (orow,ocol)=0. Reset mid-pass aborts; no partial write completes after release.
//  - All outputs are registered; nothing combinational from inputs to outputs.
//  - FSM: IDLE -> RD0 -> RD1 -> RD2 -> RD3 -> WR -> (RD0 next window | IDLE after window 1023).
//  - IDLE: ready==1 at a rising edge -> enter RD0, busy=1 from that edge. ready ignored in all other states.
//  - RDk (k=0..3): crd=1, csel=SEL_IN, caddr_rd = base+{0,1,IMG_W,IMG_W+1}[k], base=2*orow*IMG_W+2*ocol.
//    Read latency 1: cdata_rd captured at the rising edge ending RDk (data for address k).
//  - Max: unsigned DW-bit compare; ties keep earlier value (result identical). Running max register
//    loaded (not compared) with d0 at end of RD0; at end of RD3 cdata_wr <= max(run, d3) in same edge.
//  - WR: cwr=1, csel=SEL_OUT, crd=0, caddr_wr=orow*(IMG_W/2)+ocol; exactly one write cycle per window.
//  - Raster order: ocol increments 0..IMG_W/2-1 then wraps to 0 with orow++; after (31,31) -> IDLE.
//  - Throughput 5 cycles/output; full pass = 5*1024 = 5120 cycles; busy falls at edge ending last WR.
//  - Back-to-back: if ready is still 1 in the first IDLE cycle after completion, a new pass starts.
//  - cdata_rd is don't-care (may be X) whenever crd==0; it must never reach state or outputs then.
// STRUCTURE
//  - Shared package (cnn_pkg): DW, AW, IMG_W, SEL_IN/SEL_OUT csel codes, FSM state encoding.
//  - One sub-module: pool_addr_gen (orow/ocol counters, 4 read-address offsets, write address, last-window flag).
//  - Top holds FSM, running-max register, output registers.
// TESTING
//  - Ramp: L0[a]=a -> L1[i] = 2*(i/32)*64 + 2*(i%32) + 65 for all i; e.g. L1[0]=65, L1[1023]=4095.
//  - Max position sweep: per window max placed at offset 0,1,64,65 in rotation -> each output equals that max.
//  - Extremes: all-zero map -> L1 all 0; one pixel 20'hFFFFF at addr 4095, rest 1 -> L1[1023]=FFFFF, others 1.
//  - Protocol: check per window reads exactly base,+1,+64,+65 with csel=001, then one cwr with csel=011;
//    no cwr during crd; last window reads 4030,4031,4094,4095 and writes addr 1023; busy high 5120 cycles.
//  - Reset mid-pass: assert reset at window 300 RD2 -> outputs 0 immediately; after restart full map correct.
//  - Handshake: ready pulsed while busy -> ignored; ready held high across completion -> second pass identical.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared constants, csel codes and FSM encoding for the CNN result-memory stages.
package cnn_pkg;

   localparam int unsigned DW      = 20;
   localparam int unsigned AW      = 12;
   localparam int unsigned IMG_W   = 64;
   localparam int unsigned OUT_W   = IMG_W / 2;
   localparam int unsigned LOG_W   = $clog2(IMG_W);
   localparam int unsigned CW      = $clog2(OUT_W);
   localparam int unsigned NUM_WIN = OUT_W * OUT_W;

   localparam logic [2:0] SEL_IDLE = 3'b000;
   localparam logic [2:0] SEL_IN   = 3'b001;
   localparam logic [2:0] SEL_OUT  = 3'b011;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD0  = 3'd1,
      ST_RD1  = 3'd2,
      ST_RD2  = 3'd3,
      ST_RD3  = 3'd4,
      ST_WR   = 3'd5
   } state_e;

   // Which pixel of the 2x2 window is being read: (row, col) offsets.
   typedef enum logic [1:0] {
      OFF_00 = 2'd0,
      OFF_01 = 2'd1,
      OFF_10 = 2'd2,
      OFF_11 = 2'd3
   } rd_off_e;

   // Unsigned max; on a tie the first argument (earlier pixel) is kept.
   function automatic logic [DW-1:0] max_u(input logic [DW-1:0] a, input logic [DW-1:0] b);
      return (b > a) ? b : a;
   endfunction

endpackage

// File: rtl/pool_addr_gen.sv
// Window counters and address generation for 2x2 stride-2 pooling.
// Read address reflects the counters after an optional step, so the top can
// register the first read of the next window on the same edge that ends WR.
module pool_addr_gen
   import cnn_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          step_i,
   input  rd_off_e       off_i,
   output logic [AW-1:0] rd_addr_c_o,
   output logic [AW-1:0] wr_addr_c_o,
   output logic          last_c_o
);

   logic [CW-1:0] orow_q, orow_d;
   logic [CW-1:0] ocol_q, ocol_d;
   logic [AW-1:0] base;
   logic [AW-1:0] offset;

   // Raster advance: column first, row on column wrap; row wraps after the last window.
   always_comb begin
      orow_d = orow_q;
      ocol_d = ocol_q;
      if (step_i) begin
         if (ocol_q == CW'(OUT_W - 1)) begin
            ocol_d = '0;
            orow_d = orow_q + CW'(1);
         end else begin
            ocol_d = ocol_q + CW'(1);
         end
      end
   end

   // Window counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         orow_q <= '0;
         ocol_q <= '0;
      end else begin
         orow_q <= orow_d;
         ocol_q <= ocol_d;
      end
   end

   // Read address: window base (2*orow row, 2*ocol column) plus pixel offset.
   always_comb begin
      base = (AW'(orow_d) << (LOG_W + 1)) + (AW'(ocol_d) << 1);
      unique case (off_i)
         OFF_00:  offset = '0;
         OFF_01:  offset = AW'(1);
         OFF_10:  offset = AW'(IMG_W);
         OFF_11:  offset = AW'(IMG_W + 1);
         default: offset = '0;
      endcase
      rd_addr_c_o = base + offset;
   end

   // Write address and last-window flag from the current window.
   always_comb begin
      wr_addr_c_o = (AW'(orow_q) << CW) + AW'(ocol_q);
      last_c_o    = (orow_q == CW'(OUT_W - 1)) && (ocol_q == CW'(OUT_W - 1));
   end

endmodule

// File: rtl/pool2x2_engine.sv
// 2x2 stride-2 max-pooling engine: reads the layer-0 map over the result-memory
// bus, one window at a time, and writes the max of each window to layer-1.
// All bus outputs are registered from the next state, so each output is valid
// for the whole cycle of the state it belongs to.
module pool2x2_engine
   import cnn_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   input  logic          ready,
   output logic          busy,
   output logic          crd,
   output logic [AW-1:0] caddr_rd,
   input  logic [DW-1:0] cdata_rd,
   output logic          cwr,
   output logic [AW-1:0] caddr_wr,
   output logic [DW-1:0] cdata_wr,
   output logic [2:0]    csel
);

   state_e        state_q, state_d;
   logic [DW-1:0] run_q, run_d;

   logic          busy_d;
   logic          crd_d;
   logic          cwr_d;
   logic [AW-1:0] caddr_rd_d;
   logic [AW-1:0] caddr_wr_d;
   logic [DW-1:0] cdata_wr_d;
   logic [2:0]    csel_d;

   logic          step;
   rd_off_e       off_sel;
   logic [AW-1:0] rd_addr;
   logic [AW-1:0] wr_addr;
   logic          last_win;

   pool_addr_gen u_addr_gen (
      .clk         (clk),
      .rst_n       (reset),
      .step_i      (step),
      .off_i       (off_sel),
      .rd_addr_c_o (rd_addr),
      .wr_addr_c_o (wr_addr),
      .last_c_o    (last_win)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: four reads, one write per window; ready only matters in IDLE.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (ready) state_d = ST_RD0;
         ST_RD0:  state_d = ST_RD1;
         ST_RD1:  state_d = ST_RD2;
         ST_RD2:  state_d = ST_RD3;
         ST_RD3:  state_d = ST_WR;
         ST_WR:   state_d = last_win ? ST_IDLE : ST_RD0;
         default: state_d = ST_IDLE;
      endcase
   end

   // Output and datapath next values; read data is only used in read states.
   always_comb begin
      step       = (state_q == ST_WR);
      off_sel    = OFF_00;
      busy_d     = (state_d != ST_IDLE);
      crd_d      = 1'b0;
      cwr_d      = 1'b0;
      csel_d     = SEL_IDLE;
      caddr_rd_d = caddr_rd;
      caddr_wr_d = caddr_wr;
      cdata_wr_d = cdata_wr;
      run_d      = run_q;

      unique case (state_d)
         ST_RD0:  off_sel = OFF_00;
         ST_RD1:  off_sel = OFF_01;
         ST_RD2:  off_sel = OFF_10;
         ST_RD3:  off_sel = OFF_11;
         default: off_sel = OFF_00;
      endcase

      unique case (state_d)
         ST_RD0, ST_RD1, ST_RD2, ST_RD3: begin
            crd_d      = 1'b1;
            csel_d     = SEL_IN;
            caddr_rd_d = rd_addr;
         end
         ST_WR: begin
            cwr_d      = 1'b1;
            csel_d     = SEL_OUT;
            caddr_wr_d = wr_addr;
         end
         default: ;
      endcase

      unique case (state_q)
         ST_RD0:         run_d      = cdata_rd;
         ST_RD1, ST_RD2: run_d      = max_u(run_q, cdata_rd);
         ST_RD3:         cdata_wr_d = max_u(run_q, cdata_rd);
         default: ;
      endcase
   end

   // Output and running-max registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy     <= 1'b0;
         crd      <= 1'b0;
         cwr      <= 1'b0;
         caddr_rd <= '0;
         caddr_wr <= '0;
         cdata_wr <= '0;
         csel     <= SEL_IDLE;
         run_q    <= '0;
      end else begin
         busy     <= busy_d;
         crd      <= crd_d;
         cwr      <= cwr_d;
         caddr_rd <= caddr_rd_d;
         caddr_wr <= caddr_wr_d;
         cdata_wr <= cdata_wr_d;
         csel     <= csel_d;
         run_q    <= run_d;
      end
   end

endmodule

// File: tb/tb_pool2x2_engine.sv
// Bench for pool2x2_engine: memory model, per-cycle protocol/data checker
// driven by a window-sequence model, and directed map tests.
module tb_pool2x2_engine;

   localparam logic [19:0] SENT = 20'h5A5A5;

   logic        clk = 1'b0;
   logic        reset;
   logic        ready;
   logic        busy, crd, cwr;
   logic [11:0] caddr_rd, caddr_wr;
   logic [19:0] cdata_rd, cdata_wr;
   logic [2:0]  csel;

   logic [19:0] l0      [4096];
   logic [19:0] l1      [1024];
   logic [19:0] l1_snap [1024];
   logic [19:0] exp_l1  [1024];

   int n_chk  = 0;
   int n_fail = 0;
   int ev     = 0;
   int busy_cyc = 0;
   bit busy_prev = 1'b0;

   pool2x2_engine dut (
      .clk      (clk),
      .reset    (reset),
      .ready    (ready),
      .busy     (busy),
      .crd      (crd),
      .caddr_rd (caddr_rd),
      .cdata_rd (cdata_rd),
      .cwr      (cwr),
      .caddr_wr (caddr_wr),
      .cdata_wr (cdata_wr),
      .csel     (csel)
   );

   always #5 clk = ~clk;

   // Result memory: read data appears at the falling edge of a crd cycle.
   always @(negedge clk) cdata_rd = crd ? l0[caddr_rd] : 'x;
   // Write sampled at the rising edge.
   always @(posedge clk) if (cwr) l1[caddr_wr] = cdata_wr;

   function automatic int win_base(input int w);
      return 2 * (w / 32) * 64 + 2 * (w % 32);
   endfunction

   function automatic int pix_off(input int k);
      case (k)
         0:       return 0;
         1:       return 1;
         2:       return 64;
         default: return 65;
      endcase
   endfunction

   function automatic logic [19:0] win_max(input int w);
      logic [19:0] m;
      m = 0;
      for (int k = 0; k < 4; k++)
         if (l0[win_base(w) + pix_off(k)] > m) m = l0[win_base(w) + pix_off(k)];
      return m;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Per-cycle checker: a pass is the sequence of 1024 windows, each 4 reads then 1 write.
   always @(negedge clk) begin
      if (!reset) begin
         busy_prev = 1'b0;
      end else begin
         if (busy) begin
            if (!busy_prev) begin
               ev = 0;
               busy_cyc = 0;
            end
            busy_cyc++;
            if (ev >= 5120) begin
               check("busy_beyond_pass", 64'(ev), 64'd5119);
            end else if (ev % 5 < 4) begin
               check($sformatf("read w%0d k%0d", ev / 5, ev % 5),
                     {crd, cwr, csel, caddr_rd},
                     {1'b1, 1'b0, 3'b001, 12'(win_base(ev / 5) + pix_off(ev % 5))});
            end else begin
               check($sformatf("write w%0d", ev / 5),
                     {crd, cwr, csel, caddr_wr, cdata_wr},
                     {1'b0, 1'b1, 3'b011, 12'(ev / 5), win_max(ev / 5)});
            end
            ev++;
         end else begin
            if (busy_prev) check("pass_length", 64'(busy_cyc), 64'd5120);
            check("idle_outputs", {crd, cwr, csel}, 64'd0);
         end
         busy_prev = busy;
      end
   end

   task automatic wait_busy(input bit level, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (busy === level) begin
            ok = 1'b1;
            return;
         end
         @(negedge clk);
      end
   endtask

   task automatic clear_l1();
      for (int i = 0; i < 1024; i++) l1[i] = SENT;
   endtask

   task automatic check_map(input string name);
      int mism, first;
      mism = 0;
      first = -1;
      for (int i = 0; i < 1024; i++)
         if (l1[i] !== exp_l1[i]) begin
            mism++;
            if (first < 0) first = i;
         end
      check($sformatf("%s mismatching pixels (first idx %0d)", name, first), 64'(mism), 64'd0);
   endtask

   // Pulse ready once and wait for the pass to finish.
   task automatic run_pass(input string tag, input int pulse_at);
      bit ok;
      @(negedge clk);
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      wait_busy(1'b1, 4, ok);
      check({tag, " start"}, 64'(ok), 64'd1);
      if (pulse_at > 0) begin
         repeat (pulse_at) @(negedge clk);
         ready = 1'b1;
         @(negedge clk);
         ready = 1'b0;
      end
      wait_busy(1'b0, 6000, ok);
      check({tag, " finish"}, 64'(ok), 64'd1);
      repeat (3) @(negedge clk);
      check({tag, " stays idle"}, 64'(busy), 64'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int gap;
      reset = 1'b0;
      ready = 1'b0;
      for (int a = 0; a < 4096; a++) l0[a] = 20'(a);
      clear_l1();
      repeat (3) @(negedge clk);
      check("reset_outputs", {busy, crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr}, 64'd0);
      reset = 1'b1;
      repeat (4) @(negedge clk);
      check("no_start_without_ready", 64'(busy), 64'd0);

      // Ramp map
      run_pass("ramp", 0);
      for (int i = 0; i < 1024; i++) exp_l1[i] = 20'(2 * (i / 32) * 64 + 2 * (i % 32) + 65);
      check_map("ramp");
      check("ramp L1[0]", 64'(l1[0]), 64'd65);
      check("ramp L1[33]", 64'(l1[33]), 64'd195);
      check("ramp L1[1023]", 64'(l1[1023]), 64'd4095);

      // Max position sweep, with a ready pulse mid-pass that must be ignored
      for (int w = 0; w < 1024; w++) begin
         for (int k = 0; k < 4; k++) l0[win_base(w) + pix_off(k)] = 20'((w * 3 + k) % 500);
         l0[win_base(w) + pix_off(w % 4)] = 20'(1000 + w);
      end
      clear_l1();
      run_pass("sweep", 1000);
      for (int i = 0; i < 1024; i++) exp_l1[i] = 20'(1000 + i);
      check_map("sweep");
      check("sweep L1[5]", 64'(l1[5]), 64'd1005);
      check("sweep L1[1022]", 64'(l1[1022]), 64'd2022);

      // All zero
      for (int a = 0; a < 4096; a++) l0[a] = 20'd0;
      clear_l1();
      run_pass("zero", 0);
      for (int i = 0; i < 1024; i++) exp_l1[i] = 20'd0;
      check_map("zero");

      // Single full-scale pixel in the last window
      for (int a = 0; a < 4096; a++) l0[a] = 20'd1;
      l0[4095] = 20'hFFFFF;
      clear_l1();
      run_pass("extreme", 0);
      for (int i = 0; i < 1024; i++) exp_l1[i] = 20'd1;
      exp_l1[1023] = 20'hFFFFF;
      check_map("extreme");
      check("extreme L1[1023]", 64'(l1[1023]), 64'hFFFFF);
      check("extreme L1[1022]", 64'(l1[1022]), 64'd1);

      // Reset during window 300, read 2 (address 1176+64)
      for (int a = 0; a < 4096; a++) l0[a] = 20'(a);
      clear_l1();
      @(negedge clk);
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 6000; i++) begin
         if (crd === 1'b1 && caddr_rd === 12'd1240) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("reach_window300_rd2", 64'(ok), 64'd1);
      #1 reset = 1'b0;
      #1 check("reset_midpass_outputs", {busy, crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr}, 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (5) @(negedge clk);
      check("after_abort_idle", 64'(busy), 64'd0);
      check("window300_not_written", 64'(l1[300]), 64'(SENT));
      check("window299_written", 64'(l1[299]), 64'(2 * 9 * 64 + 2 * 11 + 65));
      clear_l1();
      run_pass("restart", 0);
      for (int i = 0; i < 1024; i++) exp_l1[i] = 20'(2 * (i / 32) * 64 + 2 * (i % 32) + 65);
      check_map("restart");

      // ready held high across completion: second pass starts after one idle cycle
      for (int a = 0; a < 4096; a++) l0[a] = 20'((a * 37) & 20'hFFFFF);
      for (int i = 0; i < 1024; i++) exp_l1[i] = win_max(i);
      clear_l1();
      @(negedge clk);
      ready = 1'b1;
      @(negedge clk);
      wait_busy(1'b1, 4, ok);
      check("b2b first start", 64'(ok), 64'd1);
      wait_busy(1'b0, 6000, ok);
      check("b2b first finish", 64'(ok), 64'd1);
      for (int i = 0; i < 1024; i++) l1_snap[i] = l1[i];
      clear_l1();
      gap = 0;
      while (busy !== 1'b1 && gap < 10) begin
         gap++;
         @(negedge clk);
      end
      check("b2b idle gap", 64'(gap), 64'd1);
      ready = 1'b0;
      wait_busy(1'b0, 6000, ok);
      check("b2b second finish", 64'(ok), 64'd1);
      repeat (3) @(negedge clk);
      check("b2b stops", 64'(busy), 64'd0);
      check_map("b2b second");
      for (int i = 0; i < 1024; i++) l1[i] = l1_snap[i];
      check_map("b2b first");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
